ro_measure_sched: RTL and testbench

//   Round-robin scheduler for NUM_RO ring-oscillator counter sensors. Per sensor: clear the counter,

---
 rtl/ro_sched_pkg.sv | 25 ++
 rtl/ro_phase_timer.sv | 28 ++
 rtl/ro_measure_sched.sv | 196 +++++++++++++++++++
 tb/tb_ro_measure_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_sched_pkg.sv
// Shared types and helpers for the ring-oscillator measurement scheduler.
package ro_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_OUTPUT
    } state_t;

    localparam int DEF_CLR_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Index width for n sensors; a single sensor still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_phase_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded duration.
// A load of N makes done assert in the N-th cycle after the load edge.
module ro_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == W'(1));

endmodule

// File: rtl/ro_measure_sched.sv
// Round-robin scheduler for ring-oscillator counter sensors: clear, gated
// enable window, ripple-settle wait, capture, then hand the count out on a
// valid/ready stream.
// Optional feature macro: RO_ACCUM_EN -- sums 2^ACC_LOG2 windows per result
// (ACC_LOG2 must be >= 1 when enabled).
module ro_measure_sched
    import ro_sched_pkg::*;
#(
    parameter int NUM_RO        = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int GATE_WIDTH    = 16,
    parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ACC_LOG2      = 3,
`ifdef RO_ACCUM_EN
    localparam bit ACC_ON       = 1'b1,
`else
    localparam bit ACC_ON       = 1'b0,
`endif
    localparam int RW           = CNT_WIDTH + (ACC_ON ? ACC_LOG2 : 0),
    localparam int IW           = idx_width(NUM_RO)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic [GATE_WIDTH-1:0]       gate_cycles,
    input  logic [NUM_RO*CNT_WIDTH-1:0] ro_count,
    output logic [NUM_RO-1:0]           ro_enable,
    output logic [NUM_RO-1:0]           ro_reset,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [RW-1:0]               res_data,
    output logic [IW-1:0]               res_idx,
    output logic                        busy
);

    localparam int PW = $clog2(max2(CLR_CYCLES, SETTLE_CYCLES) + 1);
    localparam int TW = max2(GATE_WIDTH, PW);

    state_t                  state_reg, state_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic [GATE_WIDTH-1:0]   gate_reg;
    logic                    timer_load;
    logic [TW-1:0]           timer_val;
    logic                    timer_done;
    logic                    enter_clear;
    logic                    last_win;
    logic [TW-1:0]           gate_eff;
    logic [CNT_WIDTH-1:0]    cap_cnt;
    logic [NUM_RO-1:0]       sel_next;

    logic [NUM_RO-1:0]       ro_enable_reg;
    logic [NUM_RO-1:0]       ro_reset_reg;
    logic                    res_valid_reg;
    logic [RW-1:0]           res_data_reg;
    logic [IW-1:0]           res_idx_reg;
    logic                    busy_reg;

`ifdef RO_ACCUM_EN
    logic [ACC_LOG2-1:0]     win_reg;
    logic [RW-1:0]           acc_reg;
    logic [RW-1:0]           acc_sum;
    assign last_win = &win_reg;
    assign acc_sum  = ((win_reg == '0) ? '0 : acc_reg) + RW'(cap_cnt);
`else
    assign last_win = 1'b1;
`endif

    // A zero gate length still opens a one-cycle window.
    assign gate_eff = (gate_reg == '0) ? TW'(1) : TW'(gate_reg);
    assign cap_cnt  = ro_count[idx_reg*CNT_WIDTH +: CNT_WIDTH];
    assign sel_next = NUM_RO'(1) << idx_next;

    ro_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Next-state, next-index and phase-timer load decisions.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        timer_load  = 1'b0;
        timer_val   = '0;
        enter_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    state_next  = ST_CLEAR;
                    timer_load  = 1'b1;
                    timer_val   = TW'(CLR_CYCLES);
                    enter_clear = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (timer_done) begin
                    state_next = ST_GATE;
                    timer_load = 1'b1;
                    timer_val  = gate_eff;
                end
            end
            ST_GATE: begin
                if (timer_done) begin
                    state_next = ST_SETTLE;
                    timer_load = 1'b1;
                    timer_val  = TW'(SETTLE_CYCLES);
                end
            end
            ST_SETTLE: begin
                if (timer_done) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (last_win) begin
                    state_next = ST_OUTPUT;
                end else begin
                    state_next  = ST_CLEAR;
                    timer_load  = 1'b1;
                    timer_val   = TW'(CLR_CYCLES);
                    enter_clear = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (res_ready) begin
                    idx_next = (idx_reg == IW'(NUM_RO - 1)) ? '0 : idx_reg + 1'b1;
                    if (run) begin
                        state_next  = ST_CLEAR;
                        timer_load  = 1'b1;
                        timer_val   = TW'(CLR_CYCLES);
                        enter_clear = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the state being entered.
    // The selected counter stays out of clear from GATE through CAPTURE so the
    // ripple count holds until it is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            gate_reg      <= '0;
            ro_enable_reg <= '0;
            ro_reset_reg  <= '1;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_idx_reg   <= '0;
            busy_reg      <= 1'b0;
`ifdef RO_ACCUM_EN
            win_reg       <= '0;
            acc_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            if (enter_clear) begin
                gate_reg <= gate_cycles;
            end
            ro_enable_reg <= (state_next == ST_GATE) ? sel_next : '0;
            ro_reset_reg  <= (state_next inside {ST_GATE, ST_SETTLE, ST_CAPTURE}) ? ~sel_next : '1;
            res_valid_reg <= (state_next == ST_OUTPUT);
            busy_reg      <= (state_next != ST_IDLE);
            if (state_reg == ST_CAPTURE) begin
                res_idx_reg <= idx_reg;
`ifdef RO_ACCUM_EN
                acc_reg <= acc_sum;
                win_reg <= win_reg + 1'b1;
                if (last_win) begin
                    res_data_reg <= acc_sum;
                end
`else
                res_data_reg <= RW'(cap_cnt);
`endif
            end
        end
    end

    assign ro_enable = ro_enable_reg;
    assign ro_reset  = ro_reset_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_idx   = res_idx_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_ro_measure_sched.sv
// Randomized scoreboard bench for ro_measure_sched with a behavioural sensor
// model: each sensor counts k_rate per enabled cycle and clears while held in
// reset, so a window of g cycles yields k_rate*g.
module tb_ro_measure_sched;

    localparam int NUM_RO     = 4;
    localparam int CNT_WIDTH  = 32;
    localparam int GATE_WIDTH = 16;
    localparam int IW         = 2;
    localparam int ACC_LOG2   = 3;
`ifdef RO_ACCUM_EN
    localparam int NWIN = 1 << ACC_LOG2;
    localparam int RW   = CNT_WIDTH + ACC_LOG2;
`else
    localparam int NWIN = 1;
    localparam int RW   = CNT_WIDTH;
`endif
    localparam int BUDGET = 20000;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        run;
    logic [GATE_WIDTH-1:0]       gate_cycles;
    logic [NUM_RO*CNT_WIDTH-1:0] ro_count;
    logic [NUM_RO-1:0]           ro_enable;
    logic [NUM_RO-1:0]           ro_reset;
    logic                        res_valid;
    logic                        res_ready;
    logic [RW-1:0]               res_data;
    logic [IW-1:0]               res_idx;
    logic                        busy;

    always #5 clk = ~clk;

    ro_measure_sched #(
        .NUM_RO        (NUM_RO),
        .CNT_WIDTH     (CNT_WIDTH),
        .GATE_WIDTH    (GATE_WIDTH),
        .CLR_CYCLES    (2),
        .SETTLE_CYCLES (4),
        .ACC_LOG2      (ACC_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .gate_cycles (gate_cycles),
        .ro_count    (ro_count),
        .ro_enable   (ro_enable),
        .ro_reset    (ro_reset),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_idx     (res_idx),
        .busy        (busy)
    );

    // Sensor model
    logic [CNT_WIDTH-1:0] cnt_model [NUM_RO];
    int unsigned          k_rate    [NUM_RO];

    always @(posedge clk) begin
        for (int i = 0; i < NUM_RO; i++) begin
            if (ro_reset[i])       cnt_model[i] <= '0;
            else if (ro_enable[i]) cnt_model[i] <= cnt_model[i] + CNT_WIDTH'(k_rate[i]);
        end
    end

    always_comb begin
        ro_count = '0;
        for (int i = 0; i < NUM_RO; i++) ro_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_model[i];
    end

    // Consumer readiness and gate-length noise, both updated just after the edge
    logic                  ready_rand = 1'b1;
    logic [GATE_WIDTH-1:0] gate_noise = '0;
    logic                  ready_rand_en, force_low, perturb_en;
    logic [GATE_WIDTH-1:0] gate_phase;

    always @(posedge clk) begin
        ready_rand <= 1'($urandom_range(0, 1));
        gate_noise <= GATE_WIDTH'($urandom_range(0, 60));
    end

    assign res_ready   = force_low ? 1'b0 : (ready_rand_en ? ready_rand : 1'b1);
    assign gate_cycles = (perturb_en && (ro_enable != '0)) ? gate_noise : gate_phase;

    // Scoreboard
    typedef struct {
        int            idx;
        logic [RW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;
    int   model_idx = 0;
    int   exp_geff = 1;
    int   win_len [NUM_RO];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_line(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
    endtask

    function automatic logic [RW-1:0] expect_data(input int idx);
        logic [CNT_WIDTH-1:0] one;
        one = CNT_WIDTH'(k_rate[idx] * exp_geff);
        return RW'(one) * RW'(NWIN);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int tgt);
        int t = 0;
        while (accepted < tgt && t < BUDGET) begin step(); t++; end
        if (accepted < tgt) fail_line("wait_accept");
    endtask

    task automatic wait_enable();
        int t = 0;
        while (ro_enable == '0 && t < BUDGET) begin step(); t++; end
        if (ro_enable == '0) fail_line("wait_enable");
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < BUDGET) begin step(); t++; end
        chk("busy_after_stop", busy, 0);
    endtask

    task automatic set_k(input bit rnd, input int fixed);
        for (int i = 0; i < NUM_RO; i++) k_rate[i] = rnd ? $urandom_range(1, 1000) : fixed;
    endtask

    // Deliver exactly n results: run is dropped once the last window is open.
    task automatic run_phase(input int n, input int g, input bit rnd_ready, input bit pert);
        int tgt;
        gate_phase    = GATE_WIDTH'(g);
        exp_geff      = (g == 0) ? 1 : g;
        ready_rand_en = rnd_ready;
        perturb_en    = pert;
        tgt = accepted + n;
        for (int j = 0; j < n; j++) begin
            exp_q.push_back('{idx: model_idx, data: expect_data(model_idx)});
            model_idx = (model_idx + 1) % NUM_RO;
        end
        run = 1'b1;
        wait_acc(tgt - 1);
        wait_enable();
        run = 1'b0;
        wait_acc(tgt);
        wait_idle();
        perturb_en    = 1'b0;
        ready_rand_en = 1'b0;
    endtask

    initial begin
        logic [RW-1:0] held_data;
        logic [IW-1:0] held_idx;
        int            t;

        reset = 1'b1; run = 1'b0; gate_phase = '0;
        ready_rand_en = 1'b0; force_low = 1'b0; perturb_en = 1'b0;
        set_k(1'b0, 3);
        for (int i = 0; i < NUM_RO; i++) win_len[i] = 0;

        // Monitor: protocol invariants, window lengths, and result scoreboard
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    for (int i = 0; i < NUM_RO; i++) win_len[i] = 0;
                end else begin
                    chk("enable_onehot0", $onehot0(ro_enable), 1);
                    chk("enable_reset_overlap", ro_enable & ro_reset, 0);
                    for (int i = 0; i < NUM_RO; i++) begin
                        if (ro_enable[i]) win_len[i]++;
                        else if (win_len[i] != 0) begin
                            chk($sformatf("window_len_ro%0d", i), win_len[i], exp_geff);
                            win_len[i] = 0;
                        end
                    end
                    if (res_valid && res_ready) begin
                        if (exp_q.size() == 0) fail_line("unexpected_result");
                        else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("res_idx", res_idx, e.idx);
                            chk("res_data", res_data, e.data);
                            $display("result idx=%0d data=%0d expected idx=%0d data=%0d", res_idx, res_data, e.idx, e.data);
                        end
                        accepted++;
                    end
                end
            end
        join_none

        repeat (3) step();
        // Reset state under active reset
        chk("rst_ro_reset", ro_reset, 4'hF);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_idx", res_idx, 0);
        reset = 1'b0;

        // 1: idle with run low stays quiet
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_ro_reset", ro_reset, 4'hF);
            chk("idle_ro_enable", ro_enable, 0);
            chk("idle_busy", busy, 0);
            chk("idle_res_valid", res_valid, 0);
        end

        // 2: gate=10, rate 3, ready always high, five results wrapping idx
        set_k(1'b0, 3);
        run_phase(5, 10, 1'b0, 1'b0);

        // 3: gate=0 (one-cycle window); consumer stalls 20 cycles
        set_k(1'b1, 0);
        gate_phase = '0;
        exp_geff   = 1;
        exp_q.push_back('{idx: model_idx, data: expect_data(model_idx)});
        model_idx = (model_idx + 1) % NUM_RO;
        force_low = 1'b1;
        run = 1'b1;
        t = 0;
        while (!res_valid && t < BUDGET) begin step(); t++; end
        if (!res_valid) fail_line("wait_valid");
        run = 1'b0;
        held_data = res_data;
        held_idx  = res_idx;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, held_data);
            chk("stall_idx", res_idx, held_idx);
            chk("stall_no_window", ro_enable, 0);
        end
        force_low = 1'b0;
        wait_acc(accepted + 1);
        wait_idle();

        // 4: stop on idx 2 during its gate, then resume at idx 3
        set_k(1'b1, 0);
        run_phase(((2 - model_idx + NUM_RO) % NUM_RO) + 1, $urandom_range(1, 20), 1'b1, 1'b1);
        chk("stop_idx_model", model_idx, 3);
        set_k(1'b1, 0);
        run_phase(3, $urandom_range(0, 25), 1'b1, 1'b1);

        // 5: reset asserted inside a gate window
        set_k(1'b1, 0);
        gate_phase = GATE_WIDTH'(15);
        exp_geff   = 15;
        run = 1'b1;
        wait_enable();
        reset = 1'b1;
        run   = 1'b0;
        step();
        chk("rstgate_ro_enable", ro_enable, 0);
        chk("rstgate_ro_reset", ro_reset, 4'hF);
        chk("rstgate_busy", busy, 0);
        chk("rstgate_res_valid", res_valid, 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        model_idx = 0;
        set_k(1'b1, 0);
        run_phase(2, $urandom_range(1, 12), 1'b1, 1'b0);

        // Random mixed phases
        for (int p = 0; p < 3; p++) begin
            set_k(1'b1, 0);
            run_phase($urandom_range(1, 5), $urandom_range(0, 30), 1'b1, 1'b1);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
